fifo_sync_param: RTL

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem_2p.sv | 23 ++
 rtl/fifo_sync_param.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers, default thresholds and access-kind encoding
// for the synchronous show-ahead FIFO.
package fifo_pkg;

  localparam int DEF_AE_LEVEL = 2;

  // Pointer/count width: one extra bit above the address holds the wrap flag.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int def_af_level(input int depth);
    return depth - 2;
  endfunction

  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_WR   = 2'b01,
    ACC_RD   = 2'b10,
    ACC_BOTH = 2'b11
  } acc_e;

endpackage

// File: rtl/fifo_mem_2p.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem_2p #(
  parameter int width = 11,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(depth)-1:0] wr_addr,
  input  logic [width-1:0]         wr_data,
  input  logic [$clog2(depth)-1:0] rd_addr,
  output logic [width-1:0]         rd_data
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Synchronous show-ahead FIFO: pointers, occupancy count and status/error
// flags around a two-port storage array.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int bw       = 11,
  parameter int simd     = 1,
  parameter int depth    = 16,
  parameter int af_level = def_af_level(depth),
  parameter int ae_level = DEF_AE_LEVEL
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          wr,
  input  logic [simd*bw-1:0]            in,
  input  logic                          rd,
  output logic [simd*bw-1:0]            out,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic [ptr_width(depth)-1:0]   o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int W  = simd * bw;
  localparam int PW = ptr_width(depth);
  localparam int AW = PW - 1;

  localparam logic [PW-1:0] FULL_CNT = PW'(depth);
  localparam logic [PW-1:0] AF_CNT   = PW'(af_level);
  localparam logic [PW-1:0] AE_CNT   = PW'(ae_level);

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          rd_acc, wr_acc;
  acc_e          acc;

  // Accept decisions use only registered state, so a full FIFO may take a
  // write when the same cycle's read frees a slot, but an empty one never
  // forwards the incoming word to the reader.
  always_comb begin
    rd_acc = rd && (count != '0);
    wr_acc = wr && ((count != FULL_CNT) || rd_acc);
    acc    = acc_e'({rd_acc, wr_acc});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case (acc)
        ACC_WR:  count <= count + 1'b1;
        ACC_RD:  count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && !wr_acc) o_overflow  <= 1'b1;
      if (rd && !rd_acc) o_underflow <= 1'b1;
    end
  end

  always_comb begin
    o_count        = count;
    o_full         = (count == FULL_CNT);
    o_empty        = (count == '0);
    o_almost_full  = (count >= AF_CNT);
    o_almost_empty = (count <= AE_CNT);
  end

  fifo_mem_2p #(
    .width(W),
    .depth(depth)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc && !flush),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data(in),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(out)
  );

endmodule
